// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_adder_pkg: shared state encoding and sizing for the adder   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CW    = $clog2(DEFAULT_WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_adder: LSB-first bit-serial adder with load/shift control   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic             w_bit, w_cout;

  assign w_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign w_cout = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  // Look-ahead during shift so a capture on the final shift edge sees the full result.
  assign sum = shift ? {w_bit, sum_q[WIDTH-1:1]} : sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= b;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (shift) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= {w_bit, sum_q[WIDTH-1:1]};
      carry_q <= w_cout;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_adder_ctrl: handshake sequencer driving serial_adder        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             abort,
  output logic             add_load,
  output logic             add_shift,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             busy
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = LOAD;
      LOAD:    state_d = abort ? IDLE : SHIFT;
      // abort outranks completion on the final shift cycle
      SHIFT:   if (abort) state_d = IDLE;
               else if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    add_load  = (state_q == LOAD);
    add_shift = (state_q == SHIFT);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (state_q == LOAD)       cnt_q <= '0;
      else if (state_q == SHIFT) cnt_q <= cnt_q + 1'b1;
      if (state_q == SHIFT && state_d == DONE) sum_q <= add_sum;
    end
  end

  assign add_a   = a_q;
  assign add_b   = b_q;
  assign out_sum = sum_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_serial_adder_ctrl: controller + serial_adder against a model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_serial_adder_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, in_valid, abort, out_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_ready, add_load, add_shift, out_valid, busy;
  logic [W-1:0] add_a, add_b, add_sum, out_sum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl #(.WIDTH(W)) u_ctrl (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .abort(abort), .add_load(add_load),
    .add_shift(add_shift), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
  );

  serial_adder #(.WIDTH(W)) u_add (
    .clk(clk), .reset(reset), .load(add_load), .shift(add_shift),
    .a(add_a), .b(add_b), .sum(add_sum)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: time since accept decides the strobes; result is plain modular addition.
  bit m_busy;
  int m_k, m_a, m_b, m_sum;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_k = 0; m_a = 0; m_b = 0; m_sum = 0;
    end else if (!m_busy) begin
      if (in_valid) begin m_busy = 1; m_k = 1; m_a = in_a; m_b = in_b; end
    end else if (m_k >= W + 2) begin
      if (out_ready) m_busy = 0;
    end else if (abort) begin
      m_busy = 0;
    end else begin
      m_k++;
      if (m_k == W + 2) m_sum = (m_a + m_b) % (1 << W);
    end
  end

  int got[$];
  int load_cyc[$];
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready",  in_ready,  !m_busy);
      chk("busy",      busy,      m_busy);
      chk("add_load",  add_load,  m_busy && m_k == 1);
      chk("add_shift", add_shift, m_busy && m_k >= 2 && m_k <= W + 1);
      chk("out_valid", out_valid, m_busy && m_k >= W + 2);
      chk("out_sum",   out_sum,   m_sum);
      chk("add_a",     add_a,     m_a);
      chk("add_b",     add_b,     m_b);
      if (out_valid && out_ready) got.push_back(out_sum);
      if (add_load) load_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("wait_idle_timeout", n, 0);
  endtask

  task automatic run_add(input int a, input int b, input int exp, input string name);
    int lat, loads, shifts;
    wait_idle();
    in_a = W'(a); in_b = W'(b); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1; loads = 0; shifts = 0;
    while (!out_valid && lat < 30) begin
      loads += int'(add_load); shifts += int'(add_shift);
      tick(); lat++;
    end
    chk({name, "_latency"}, lat, W + 2);
    chk({name, "_loads"}, loads, 1);
    chk({name, "_shifts"}, shifts, W);
    chk({name, "_sum"}, out_sum, exp);
    if (out_ready) begin
      tick();
      chk({name, "_busy_after"}, busy, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, l0, n;
    reset = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_add_a", add_a, 0);
    reset = 1'b0;
    tick();

    // 1 and 2: basic add and carry wrap
    run_add(4'b1101, 4'b0010, 4'b1111, "t1");
    run_add(4'b1111, 4'b0001, 4'b0000, "t2");

    // 3: back-pressure with a stray in_valid while DONE
    out_ready = 1'b0;
    run_add(6, 7, 13, "t3");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin in_a = 4'd9; in_b = 4'd9; in_valid = 1'b1; end
      tick();
      in_valid = 1'b0;
      chk("t3_hold_sum", out_sum, 13);
      chk("t3_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_busy_after", busy, 0);
    chk("t3_add_a_kept", add_a, 6);

    // 4: abort on the second shift cycle
    wait_idle();
    in_a = 4'd2; in_b = 4'd3; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); tick();
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("t4_shift", add_shift, 0);
    chk("t4_ready", in_ready, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin tick(); n += int'(out_valid); end
    chk("t4_no_valid", n, 0);
    chk("t4_sum_kept", out_sum, 13);

    // 5: asynchronous reset between edges mid-shift
    wait_idle();
    in_a = 4'd5; in_b = 4'd5; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("t5_shift", add_shift, 0);
    chk("t5_load", add_load, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_sum", out_sum, 0);
    chk("t5_ready", in_ready, 1);
    tick(); reset = 1'b0;
    tick();

    // 6: back-to-back adds with in_valid held
    g0 = got.size(); l0 = load_cyc.size();
    in_a = 4'd3; in_b = 4'd4; in_valid = 1'b1;
    n = 0;
    while (!add_load && n < 20) begin tick(); n++; end
    in_a = 4'd5; in_b = 4'd6;
    tick();
    n = 0;
    while (!add_load && n < 30) begin tick(); n++; end
    in_valid = 1'b0;
    n = 0;
    while (got.size() < g0 + 2 && n < 40) begin tick(); n++; end
    chk("t6_count", got.size() - g0, 2);
    if (got.size() >= g0 + 2) begin
      chk("t6_sum0", got[g0], 4'b0111);
      chk("t6_sum1", got[g0 + 1], 4'b1011);
    end
    chk("t6_loads", load_cyc.size() - l0, 2);
    if (load_cyc.size() >= l0 + 2)
      chk("t6_gap", load_cyc[l0 + 1] - load_cyc[l0], W + 3);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
